screen_switcher: RTL and testbench
==================================

# screen_switcher

Parametrised video-source selector between N screen generators (start, game, end, …) and the VGA output stage. Selects one source's timing and RGB at a time and registers it to the output. Switches only on the target source's start-of-frame, so no torn frames reach the monitor. Accepts switch requests over a valid/ready handshake and drives a one-hot enable to the sources; an optional brightness fade plays between screens.

## Interface
- N_SRC, 3: number of video sources (2..8); source 0 is the power-up screen.
- CW, 11: hcount/vcount width.
- RGB_W, 12: RGB width, 4 bits per channel, {R,G,B}.
- SW, $clog2(N_SRC): select width (derived, not overridden).
- clk40  in  1  pixel clock, 40 MHz.
- rst  in  1  reset, synchronous, active-high.
- hcount_in  in  N_SRC*CW  per-source hcount; source k at [k*CW +: CW].
- vcount_in  in  N_SRC*CW  per-source vcount, same packing.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  N_SRC each  per-source timing bits, bit k = source k.
- rgb_in  in  N_SRC*RGB_W  per-source pixel.
- req_valid  in  1  switch request.
- req_sel  in  SW  requested source index.
- req_ready  out  1  high only in SHOW state (combinational from state).
- req_err  out  1  one-cycle pulse: accepted request was invalid.
- hcount_out, vcount_out  out  CW  registered selected counts.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  registered selected timing.
- rgb_out  out  RGB_W  registered, scaled pixel.
- sel_out  out  SW  index currently driving the outputs.
- src_en  out  N_SRC  one-hot enable, bit sel_out set.
- busy  out  1  high while a switch is in progress.

## Operation
- Reset values: all video outputs 0, sel_out=0, src_en=1, busy=0, req_err=0, level=16, state SHOW.
- States: SHOW, FADE_OUT, WAIT_SOF, FADE_IN. SOF(k) means hcount_in[k]==0 && vcount_in[k]==0.
- SHOW: request accepted on req_valid && req_ready. If req_sel ≥ N_SRC or req_sel == sel_out, pulse req_err next cycle and stay in SHOW. Otherwise latch target and go to FADE_OUT (fade build) or WAIT_SOF (no fade).
- FADE_OUT: at each SOF(sel_out), level -= FADE_STEP, saturating at 0. At 0 go to WAIT_SOF.
- WAIT_SOF: on the SOF(target) cycle, sel_out and src_en update to target. The output registers load the target's signals in that same cycle. Then go to FADE_IN, or SHOW without fade.
- FADE_IN: at each SOF(sel_out), level += FADE_STEP, saturating at 16. At 16 go to SHOW.
- busy = (state != SHOW). Requests arriving while busy are not accepted; req_valid must be held until accepted.
- Scaling: each 4-bit channel out = (c × level) >> 4, with level 0..16 (5 bits) and an 8..9-bit product truncated. Level 16 passes the pixel unchanged.
- Timing signals and counts are never scaled, only RGB.
- Reset mid-switch: returns to source 0 immediately at full level; the latched target is discarded.

## Timing
- Output latency: 1 cycle from source inputs to outputs, for all signals including rgb.
- Request to first target pixel, no fade: 1 cycle to WAIT_SOF, plus wait until the next SOF(target), plus 1 output register.
- With fade, FADE_STEP=1: 16 frames out, then wait for SOF(target), then 16 frames in.
- sel_out/src_en change on the same edge at which the output registers first hold target data.
- rst and req_valid in the same cycle: reset wins; the request is not accepted.

## Configuration
- SCREEN_FADE_EN defined: FADE_OUT/FADE_IN states and the scaler are built. FADE_STEP localparam defaults to 1.
- SCREEN_FADE_EN undefined: SHOW→WAIT_SOF→SHOW only, rgb passes unscaled, level logic removed. Handshake, err and SOF-aligned swap are unchanged.

## Structure
- Package screen_pkg holds:
  - state enum codes SHOW=2'b00, FADE_OUT=2'b01, WAIT_SOF=2'b10, FADE_IN=2'b11;
  - LEVEL_MAX=16;
  - default CW/RGB_W constants, shared with the source generators.
- One sub-module, rgb_scaler: combinational per-channel multiply/shift, instantiated only under SCREEN_FADE_EN.

## Test plan
- Reset, N_SRC=3: sel_out=0, src_en=3'b001, outputs equal source 0 delayed 1 cycle, req_ready=1.
- req_sel=1 accepted mid-frame, no fade: outputs keep source 0 until SOF(1), then source 1 from hcount_out=0/vcount_out=0; src_en=3'b010.
- req_sel=3 (invalid), then req_sel=sel_out: each gives a one-cycle req_err pulse, state stays SHOW, busy=0.
- Fade build, FADE_STEP=1, source pixel 12'hFFF: after 8 frames rgb_out=12'h777; after 16 frames 12'h000; swap at SOF(target); back to full scale after 16 more frames.
- req_valid held high while busy: req_ready=0, no second switch until SHOW; then accepted on the first SHOW cycle.
- rst asserted during FADE_OUT at level 5: next cycle state SHOW, sel_out=0, level=16, busy=0.

Source files
------------

// File: rtl/screen_pkg.sv
// screen_pkg: shared definitions for the screen switcher and the screen
// generators that feed it.
//   state_t        switcher FSM state codes
//   LEVEL_MAX      full-brightness fade level (pixel passes unchanged)
//   LEVEL_W        width of a fade level value (0..16 needs 5 bits)
//   CW_DEF         default hcount/vcount width
//   RGB_W_DEF      default pixel width, 4 bits per channel {R,G,B}
//   scale_chan     one 4-bit channel scaled by a fade level
package screen_pkg;

    typedef enum logic [1:0] {
        SHOW     = 2'b00,
        FADE_OUT = 2'b01,
        WAIT_SOF = 2'b10,
        FADE_IN  = 2'b11
    } state_t;

    localparam int LEVEL_MAX = 16;
    localparam int LEVEL_W   = 5;
    localparam int CW_DEF    = 11;
    localparam int RGB_W_DEF = 12;

    // (c * level) >> 4; the largest product is 15*16 = 240, so 8 bits hold it
    function automatic logic [3:0] scale_chan(input logic [3:0] c,
                                              input logic [LEVEL_W-1:0] level);
        logic [7:0] prod;
        prod = {4'b0000, c} * {3'b000, level};
        return prod[7:4];
    endfunction

endpackage

// File: rtl/rgb_scaler.sv
// rgb_scaler: combinational brightness scaler for one pixel.
// Only exists in builds with SCREEN_FADE_EN defined; otherwise this file
// contributes nothing.
//   pix         in   RGB_W  pixel, 4 bits per channel
//   level       in   5      fade level 0..16 (16 = unchanged)
//   pix_scaled  out  RGB_W  each channel = (c * level) >> 4
`ifdef SCREEN_FADE_EN
module rgb_scaler
    import screen_pkg::*;
#(
    parameter int RGB_W = RGB_W_DEF
) (
    input  logic [RGB_W-1:0]   pix,
    input  logic [LEVEL_W-1:0] level,
    output logic [RGB_W-1:0]   pix_scaled
);

    // Scale every 4-bit channel independently
    always_comb begin
        pix_scaled = {RGB_W{1'b0}};
        for (int i = 0; i < RGB_W / 4; i++) begin
            pix_scaled[i*4 +: 4] = scale_chan(pix[i*4 +: 4], level);
        end
    end

endmodule
`endif

// File: rtl/screen_switcher.sv
// screen_switcher: selects one of N_SRC screen generators and registers its
// timing and pixel data towards the VGA output stage. A source change is
// requested over req_valid/req_ready and only takes effect on the target's
// start of frame (hcount==0 && vcount==0), so no torn frame is shown.
// Optional build macro SCREEN_FADE_EN adds a brightness fade-out before and
// a fade-in after the swap; without it rgb passes unscaled.
// Ports:
//   clk40, rst                       40 MHz pixel clock, sync active-high reset
//   hcount_in, vcount_in             per-source counts, source k at [k*CW +: CW]
//   hsync/vsync/hblnk/vblnk_in       per-source timing bits, bit k = source k
//   rgb_in                           per-source pixel, source k at [k*RGB_W +: RGB_W]
//   req_valid, req_sel, req_ready    switch request handshake
//   req_err                          one-cycle pulse: accepted request was invalid
//   hcount_out..vblnk_out, rgb_out   registered selected source (1 cycle latency)
//   sel_out, src_en                  active source index and its one-hot enable
//   busy                             a switch is in progress
module screen_switcher
    import screen_pkg::*;
#(
    parameter int  N_SRC = 3,
    parameter int  CW    = CW_DEF,
    parameter int  RGB_W = RGB_W_DEF,
    localparam int SW    = $clog2(N_SRC)
) (
    input  logic                   clk40,
    input  logic                   rst,
    input  logic [N_SRC*CW-1:0]    hcount_in,
    input  logic [N_SRC*CW-1:0]    vcount_in,
    input  logic [N_SRC-1:0]       hsync_in,
    input  logic [N_SRC-1:0]       vsync_in,
    input  logic [N_SRC-1:0]       hblnk_in,
    input  logic [N_SRC-1:0]       vblnk_in,
    input  logic [N_SRC*RGB_W-1:0] rgb_in,
    input  logic                   req_valid,
    input  logic [SW-1:0]          req_sel,
    output logic                   req_ready,
    output logic                   req_err,
    output logic [CW-1:0]          hcount_out,
    output logic [CW-1:0]          vcount_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic                   hblnk_out,
    output logic                   vblnk_out,
    output logic [RGB_W-1:0]       rgb_out,
    output logic [SW-1:0]          sel_out,
    output logic [N_SRC-1:0]       src_en,
    output logic                   busy
);

    localparam logic [SW:0]      N_SRC_V = (SW+1)'(N_SRC);
    localparam logic [N_SRC-1:0] EN_SRC0 = {{(N_SRC-1){1'b0}}, 1'b1};

    logic [CW-1:0]    hc_s  [N_SRC];
    logic [CW-1:0]    vc_s  [N_SRC];
    logic [RGB_W-1:0] pix_s [N_SRC];
    logic [N_SRC-1:0] sof_s;

    state_t           state_r;
    state_t           next_state_s;
    logic [SW-1:0]    sel_r;
    logic [SW-1:0]    target_r;
    logic [N_SRC-1:0] src_en_r;
    logic             req_err_r;

    logic             accept_s;
    logic             invalid_s;
    logic             sof_cur_s;
    logic             sof_tgt_s;
    logic             swap_s;
    logic [SW-1:0]    mux_idx_s;
    logic [RGB_W-1:0] pix_sel_s;
    logic [RGB_W-1:0] rgb_scaled_s;

`ifdef SCREEN_FADE_EN
    localparam logic [LEVEL_W-1:0] FADE_STEP   = 5'd1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX_V = LEVEL_W'(LEVEL_MAX);

    logic [LEVEL_W-1:0] level_r;
    logic [LEVEL_W-1:0] level_nxt_s;
    logic [LEVEL_W-1:0] level_dn_s;
    logic [LEVEL_W:0]   level_sum_s;
    logic [LEVEL_W-1:0] level_up_s;
`endif

    // Unpack the per-source buses and detect each source's start of frame
    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            hc_s[k]  = hcount_in[k*CW +: CW];
            vc_s[k]  = vcount_in[k*CW +: CW];
            pix_s[k] = rgb_in[k*RGB_W +: RGB_W];
            sof_s[k] = (hc_s[k] == {CW{1'b0}}) && (vc_s[k] == {CW{1'b0}});
        end
    end

    assign accept_s  = req_valid && (state_r == SHOW);
    // Out-of-range indices and a request for the already shown source are errors
    assign invalid_s = ({1'b0, req_sel} >= N_SRC_V) || (req_sel == sel_r);
    assign sof_cur_s = sof_s[sel_r];
    assign sof_tgt_s = sof_s[target_r];
    // The target's SOF pixel is the first one routed to the outputs
    assign swap_s    = (state_r == WAIT_SOF) && sof_tgt_s;
    assign mux_idx_s = swap_s ? target_r : sel_r;
    assign pix_sel_s = pix_s[mux_idx_s];

`ifdef SCREEN_FADE_EN
    assign level_dn_s  = (level_r > FADE_STEP) ? (level_r - FADE_STEP) : 5'd0;
    assign level_sum_s = {1'b0, level_r} + {1'b0, FADE_STEP};
    assign level_up_s  = (level_sum_s >= {1'b0, LEVEL_MAX_V}) ? LEVEL_MAX_V
                                                              : level_sum_s[LEVEL_W-1:0];

    rgb_scaler #(
        .RGB_W (RGB_W)
    ) u_rgb_scaler (
        .pix        (pix_sel_s),
        .level      (level_r),
        .pix_scaled (rgb_scaled_s)
    );
`else
    assign rgb_scaled_s = pix_sel_s;
`endif

    // FSM state register
    always_ff @(posedge clk40) begin
        if (rst) begin
            state_r <= SHOW;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state and next fade level
    always_comb begin
        next_state_s = state_r;
`ifdef SCREEN_FADE_EN
        level_nxt_s  = level_r;
`endif
        case (state_r)
            SHOW: begin
                if (accept_s && !invalid_s) begin
`ifdef SCREEN_FADE_EN
                    next_state_s = FADE_OUT;
`else
                    next_state_s = WAIT_SOF;
`endif
                end else begin
                    next_state_s = SHOW;
                end
            end
`ifdef SCREEN_FADE_EN
            // Dim the current source one step per frame of that source
            FADE_OUT: begin
                if (sof_cur_s) begin
                    level_nxt_s = level_dn_s;
                    if (level_dn_s == 5'd0) begin
                        next_state_s = WAIT_SOF;
                    end else begin
                        next_state_s = FADE_OUT;
                    end
                end else begin
                    next_state_s = FADE_OUT;
                end
            end
            // Brighten the new source one step per frame of that source
            FADE_IN: begin
                if (sof_cur_s) begin
                    level_nxt_s = level_up_s;
                    if (level_up_s == LEVEL_MAX_V) begin
                        next_state_s = SHOW;
                    end else begin
                        next_state_s = FADE_IN;
                    end
                end else begin
                    next_state_s = FADE_IN;
                end
            end
`endif
            WAIT_SOF: begin
                if (swap_s) begin
`ifdef SCREEN_FADE_EN
                    next_state_s = FADE_IN;
`else
                    next_state_s = SHOW;
`endif
                end else begin
                    next_state_s = WAIT_SOF;
                end
            end
            default: begin
                next_state_s = SHOW;
            end
        endcase
    end

`ifdef SCREEN_FADE_EN
    // Fade level register; reset restores full brightness
    always_ff @(posedge clk40) begin
        if (rst) begin
            level_r <= LEVEL_MAX_V;
        end else begin
            level_r <= level_nxt_s;
        end
    end
`endif

    // Request target latch, error pulse and active-source selection
    always_ff @(posedge clk40) begin
        if (rst) begin
            sel_r     <= {SW{1'b0}};
            target_r  <= {SW{1'b0}};
            src_en_r  <= EN_SRC0;
            req_err_r <= 1'b0;
        end else begin
            req_err_r <= accept_s && invalid_s;
            if (accept_s && !invalid_s) begin
                target_r <= req_sel;
            end
            if (swap_s) begin
                sel_r    <= target_r;
                src_en_r <= EN_SRC0 << target_r;
            end
        end
    end

    // Output registers load the routed source; only rgb is scaled
    always_ff @(posedge clk40) begin
        if (rst) begin
            hcount_out <= {CW{1'b0}};
            vcount_out <= {CW{1'b0}};
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= {RGB_W{1'b0}};
        end else begin
            hcount_out <= hc_s[mux_idx_s];
            vcount_out <= vc_s[mux_idx_s];
            hsync_out  <= hsync_in[mux_idx_s];
            vsync_out  <= vsync_in[mux_idx_s];
            hblnk_out  <= hblnk_in[mux_idx_s];
            vblnk_out  <= vblnk_in[mux_idx_s];
            rgb_out    <= rgb_scaled_s;
        end
    end

    assign req_ready = (state_r == SHOW);
    assign busy      = (state_r != SHOW);
    assign req_err   = req_err_r;
    assign sel_out   = sel_r;
    assign src_en    = src_en_r;

endmodule

// File: tb/tb_screen_switcher.sv
// tb_screen_switcher: directed bench for screen_switcher with three sources.
// Each source is a small 8x4 frame counter with its own phase, so the
// start-of-frame points of the sources differ. Expected outputs are the
// bench's own pre-edge source values or hand-computed constants.
module tb_screen_switcher;

    localparam int NS    = 3;
    localparam int CWT   = 11;
    localparam int RW    = 12;
    localparam int SWT   = 2;
    localparam int H_TOT = 8;
    localparam int V_TOT = 4;

    logic              clk40;
    logic              rst;
    logic [NS*CWT-1:0] hcount_in;
    logic [NS*CWT-1:0] vcount_in;
    logic [NS-1:0]     hsync_in;
    logic [NS-1:0]     vsync_in;
    logic [NS-1:0]     hblnk_in;
    logic [NS-1:0]     vblnk_in;
    logic [NS*RW-1:0]  rgb_in;
    logic              req_valid;
    logic [SWT-1:0]    req_sel;
    logic              req_ready;
    logic              req_err;
    logic [CWT-1:0]    hcount_out;
    logic [CWT-1:0]    vcount_out;
    logic              hsync_out;
    logic              vsync_out;
    logic              hblnk_out;
    logic              vblnk_out;
    logic [RW-1:0]     rgb_out;
    logic [SWT-1:0]    sel_out;
    logic [NS-1:0]     src_en;
    logic              busy;

    int n_cmp = 0;
    int n_mis = 0;

    int sh [NS];
    int sv [NS];
    bit pix_fff = 1'b0;

    logic [NS*CWT-1:0] p_hc;
    logic [NS*CWT-1:0] p_vc;
    logic [NS-1:0]     p_hs;
    logic [NS-1:0]     p_vs;
    logic [NS-1:0]     p_hb;
    logic [NS-1:0]     p_vb;
    logic [NS*RW-1:0]  p_rgb;

    screen_switcher #(
        .N_SRC (NS),
        .CW    (CWT),
        .RGB_W (RW)
    ) dut (
        .clk40      (clk40),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .req_err    (req_err),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .sel_out    (sel_out),
        .src_en     (src_en),
        .busy       (busy)
    );

    initial clk40 = 1'b0;
    always #5 clk40 = ~clk40;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < NS; k++) begin
            hcount_in[k*CWT +: CWT] = CWT'(sh[k]);
            vcount_in[k*CWT +: CWT] = CWT'(sv[k]);
            hsync_in[k] = (sh[k] == 6);
            hblnk_in[k] = (sh[k] >= 6);
            vsync_in[k] = (sv[k] == 3);
            vblnk_in[k] = (sv[k] >= 2);
            rgb_in[k*RW +: RW] = pix_fff ? 12'hFFF
                                         : {4'(k*4+3), 4'(sh[k]), 4'(sv[k]*3+k)};
        end
    endtask

    // Snapshot the inputs, cross one rising edge, then advance the sources
    task automatic tick();
        p_hc  = hcount_in;
        p_vc  = vcount_in;
        p_hs  = hsync_in;
        p_vs  = vsync_in;
        p_hb  = hblnk_in;
        p_vb  = vblnk_in;
        p_rgb = rgb_in;
        @(posedge clk40);
        #1;
        for (int k = 0; k < NS; k++) begin
            sh[k]++;
            if (sh[k] == H_TOT) begin
                sh[k] = 0;
                sv[k] = (sv[k] + 1) % V_TOT;
            end
        end
        drive_src();
    endtask

    function automatic bit p_sof(input int k);
        return (p_hc[k*CWT +: CWT] == 11'd0) && (p_vc[k*CWT +: CWT] == 11'd0);
    endfunction

    task automatic check_src(input string tag, input int k);
        check({tag, "_hcount"}, 32'(hcount_out), 32'(p_hc[k*CWT +: CWT]));
        check({tag, "_vcount"}, 32'(vcount_out), 32'(p_vc[k*CWT +: CWT]));
        check({tag, "_timing"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
              32'({p_hs[k], p_vs[k], p_hb[k], p_vb[k]}));
        check({tag, "_rgb"}, 32'(rgb_out), 32'(p_rgb[k*RW +: RW]));
    endtask

    // Tick until source k has shown `count` start-of-frame pixels
    task automatic wait_sof(input int k, input int count, input string tag);
        int n = 0;
        for (int i = 0; i < (count + 2) * H_TOT * V_TOT && n < count; i++) begin
            tick();
            if (p_sof(k)) n++;
        end
        check(tag, 32'(n), 32'(count));
    endtask

    initial begin
        bit done;
        sh[0] = 0; sv[0] = 0;
        sh[1] = 3; sv[1] = 1;
        sh[2] = 5; sv[2] = 2;
        rst = 1'b1;
        req_valid = 1'b0;
        req_sel = 2'd0;
        drive_src();

        // Reset state
        repeat (3) tick();
        check("rst_hcount", 32'(hcount_out), 32'd0);
        check("rst_rgb", 32'(rgb_out), 32'h000);
        check("rst_timing", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        check("rst_sel", 32'(sel_out), 32'd0);
        check("rst_src_en", 32'(src_en), 32'b001);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_err", 32'(req_err), 32'd0);

        // Source 0 shown with one cycle latency
        rst = 1'b0;
        repeat (3) begin
            tick();
            check_src("show0", 0);
        end

        // Invalid index
        req_valid = 1'b1; req_sel = 2'd3;
        tick();
        req_valid = 1'b0;
        check("err_range_pulse", 32'(req_err), 32'd1);
        check("err_range_busy", 32'(busy), 32'd0);
        check("err_range_sel", 32'(sel_out), 32'd0);
        tick();
        check("err_range_end", 32'(req_err), 32'd0);

        // Request for the source already shown
        req_valid = 1'b1; req_sel = 2'd0;
        tick();
        req_valid = 1'b0;
        check("err_same_pulse", 32'(req_err), 32'd1);
        check("err_same_busy", 32'(busy), 32'd0);
        tick();
        check("err_same_end", 32'(req_err), 32'd0);
        check("err_same_ready", 32'(req_ready), 32'd1);

`ifndef SCREEN_FADE_EN
        // Switch to source 1 mid-frame; swap exactly at SOF(1)
        req_valid = 1'b1; req_sel = 2'd1;
        tick();
        req_valid = 1'b0;
        check("sw1_busy", 32'(busy), 32'd1);
        check("sw1_ready", 32'(req_ready), 32'd0);
        check("sw1_sel_hold", 32'(sel_out), 32'd0);
        check_src("sw1_accept", 0);
        done = 1'b0;
        for (int i = 0; i < 2 * H_TOT * V_TOT && !done; i++) begin
            tick();
            if (p_sof(1)) begin
                check_src("sw1_first", 1);
                check("sw1_first_h0", 32'(hcount_out), 32'd0);
                check("sw1_first_v0", 32'(vcount_out), 32'd0);
                check("sw1_sel", 32'(sel_out), 32'd1);
                check("sw1_src_en", 32'(src_en), 32'b010);
                check("sw1_idle", 32'(busy), 32'd0);
                done = 1'b1;
            end else begin
                check_src("sw1_keep0", 0);
                check("sw1_keep_sel", 32'(sel_out), 32'd0);
            end
        end
        check("sw1_timeout", 32'(done), 32'd1);
        tick();
        check_src("show1", 1);

        // Switch to 2, then hold a second request (to 0) while busy
        req_valid = 1'b1; req_sel = 2'd2;
        tick();
        check("hold_busy", 32'(busy), 32'd1);
        req_sel = 2'd0;
        done = 1'b0;
        for (int i = 0; i < 2 * H_TOT * V_TOT && !done; i++) begin
            tick();
            if (p_sof(2)) begin
                check_src("hold_first2", 2);
                check("hold_sel2", 32'(sel_out), 32'd2);
                check("hold_src_en2", 32'(src_en), 32'b100);
                check("hold_ready_show", 32'(req_ready), 32'd1);
                done = 1'b1;
            end else begin
                check("hold_not_ready", 32'(req_ready), 32'd0);
                check("hold_sel1", 32'(sel_out), 32'd1);
            end
        end
        check("hold_timeout", 32'(done), 32'd1);
        tick();
        req_valid = 1'b0;
        check("hold_accept_busy", 32'(busy), 32'd1);
        check("hold_accept_sel", 32'(sel_out), 32'd2);
        done = 1'b0;
        for (int i = 0; i < 2 * H_TOT * V_TOT && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        check("hold_idle_timeout", 32'(done), 32'd1);
        check("hold_sel0", 32'(sel_out), 32'd0);
        check("hold_src_en0", 32'(src_en), 32'b001);

        // Reset during WAIT_SOF discards the target
        req_valid = 1'b1; req_sel = 2'd1;
        tick();
        req_valid = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rstmid_idle", 32'(busy), 32'd0);
        check("rstmid_sel", 32'(sel_out), 32'd0);
        check("rstmid_src_en", 32'(src_en), 32'b001);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();
        check_src("rstmid_show0", 0);
        repeat (2 * H_TOT * V_TOT) tick();
        check("rstmid_no_swap", 32'(sel_out), 32'd0);
        check_src("rstmid_still0", 0);
`else
        // Fade out of 0 into 1 with white pixels on every source
        pix_fff = 1'b1;
        drive_src();
        req_valid = 1'b1; req_sel = 2'd1;
        tick();
        req_valid = 1'b0;
        check("fade_busy", 32'(busy), 32'd1);
        wait_sof(0, 8, "fo8_count");
        tick();
        check("fo8_rgb", 32'(rgb_out), 32'h777);
        check("fo8_sel", 32'(sel_out), 32'd0);
        wait_sof(0, 8, "fo16_count");
        tick();
        check("fo16_rgb", 32'(rgb_out), 32'h000);
        check("fo16_busy", 32'(busy), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 2 * H_TOT * V_TOT && !done; i++) begin
            tick();
            if (p_sof(1)) begin
                check("fswap_sel", 32'(sel_out), 32'd1);
                check("fswap_src_en", 32'(src_en), 32'b010);
                check("fswap_h0", 32'(hcount_out), 32'd0);
                check("fswap_v0", 32'(vcount_out), 32'd0);
                check("fswap_rgb", 32'(rgb_out), 32'h000);
                done = 1'b1;
            end else begin
                check("fwait_sel", 32'(sel_out), 32'd0);
            end
        end
        check("fswap_timeout", 32'(done), 32'd1);
        wait_sof(1, 8, "fi8_count");
        tick();
        check("fi8_rgb", 32'(rgb_out), 32'h777);
        wait_sof(1, 8, "fi16_count");
        tick();
        check("fi16_rgb", 32'(rgb_out), 32'hFFF);
        check("fi16_idle", 32'(busy), 32'd0);
        check("fi16_ready", 32'(req_ready), 32'd1);

        // Reset during fade-out at level 5
        req_valid = 1'b1; req_sel = 2'd0;
        tick();
        req_valid = 1'b0;
        wait_sof(1, 11, "fo11_count");
        tick();
        check("fo11_rgb", 32'(rgb_out), 32'h444);
        rst = 1'b1;
        tick();
        check("frst_idle", 32'(busy), 32'd0);
        check("frst_sel", 32'(sel_out), 32'd0);
        check("frst_src_en", 32'(src_en), 32'b001);
        check("frst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();
        check_src("frst_show0", 0);
        pix_fff = 1'b0;
        drive_src();
`endif

        // Reset and request in the same cycle: reset wins
        rst = 1'b1; req_valid = 1'b1; req_sel = 2'd1;
        tick();
        check("rstreq_idle", 32'(busy), 32'd0);
        check("rstreq_err", 32'(req_err), 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        tick();
        check("rstreq_idle2", 32'(busy), 32'd0);
        check("rstreq_sel", 32'(sel_out), 32'd0);
        check_src("rstreq_show0", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
